// File: rtl/batcharger_ctrl.sv
// Charge-sequencing FSM for the battery charger power stage.
// Walks trickle -> constant-current -> constant-voltage -> end-of-charge
// from ADC codes, with debounced transitions, a CV safety timer,
// temperature/enable abort and automatic recharge from END.
module batcharger_ctrl #(
   parameter int DEB_N = 4,
   parameter int TMR_W = 16,
   parameter int VRECH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [7:0]       vbat,
   input  logic [7:0]       ibat,
   input  logic [7:0]       tbat,
   input  logic [7:0]       vcutoff,
   input  logic [7:0]       vpreset,
   input  logic [7:0]       vtarget,
   input  logic [7:0]       iend,
   input  logic [7:0]       tempmin,
   input  logic [7:0]       tempmax,
   input  logic [TMR_W-1:0] tmax,
   output logic             cc,
   output logic             tc,
   output logic             cv,
   output logic             chg_done,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SENSE = 3'd1,
      S_TC    = 3'd2,
      S_CC    = 3'd3,
      S_CV    = 3'd4,
      S_END   = 3'd5
   } state_t;

   // Counter only has to reach DEB_N-1; the transition fires there.
   localparam int CNT_W = (DEB_N > 1) ? $clog2(DEB_N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);
   localparam logic [9:0]       VRECH_C  = 10'(VRECH);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d, tmr_inc;
   logic               cc_q, cc_d, tc_q, tc_d, cv_q, cv_d, done_q, done_d;
   logic               temp_ok, abort, cond, rech_low;

   assign temp_ok = (tbat >= tempmin) && (tbat <= tempmax);
   assign abort   = !en || !temp_ok;
   // vbat < sat(vtarget - VRECH) rewritten as vbat + VRECH < vtarget so the
   // clamp at zero falls out naturally (never true when vtarget < VRECH).
   assign rech_low = ({2'b00, vbat} + VRECH_C) < {2'b00, vtarget};

   // Next-state, debounce counter, CV timer and output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      tmr_d   = '0;
      cond    = 1'b0;
      tmr_inc = (&tmr_q) ? tmr_q : tmr_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (en && temp_ok) state_d = S_SENSE;
         end
         S_SENSE: begin
            if (vbat < vcutoff)      state_d = S_TC;
            else if (vbat < vpreset) state_d = S_CC;
            else if (vbat < vtarget) state_d = S_CV;
            else                     state_d = S_END;
         end
         S_TC: begin
            cond = (vbat >= vcutoff);
            if (cond && cnt_q == CNT_LAST) state_d = S_CC;
         end
         S_CC: begin
            cond = (vbat >= vpreset);
            if (cond && cnt_q == CNT_LAST) state_d = S_CV;
         end
         S_CV: begin
            cond  = (ibat <= iend);
            tmr_d = tmr_inc;
            if ((cond && cnt_q == CNT_LAST) || (tmax != '0 && tmr_inc == tmax))
               state_d = S_END;
         end
         S_END: begin
            cond = rech_low;
            if (cond && cnt_q == CNT_LAST) state_d = S_SENSE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE && abort) state_d = S_IDLE;
      // Timer only survives while staying in CV; any entry starts from zero.
      if (state_d != S_CV || state_q != S_CV) tmr_d = '0;
      if (cond && state_d == state_q)
         cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
      tc_d   = (state_d == S_TC);
      cc_d   = (state_d == S_CC);
      cv_d   = (state_d == S_CV);
      done_d = (state_d == S_END);
   end

   // State, counters and registered Moore outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tmr_q   <= '0;
         cc_q    <= 1'b0;
         tc_q    <= 1'b0;
         cv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         cc_q    <= cc_d;
         tc_q    <= tc_d;
         cv_q    <= cv_d;
         done_q  <= done_d;
      end
   end

   assign cc       = cc_q;
   assign tc       = tc_q;
   assign cv       = cv_q;
   assign chg_done = done_q;
   assign state    = state_q;

endmodule
